// File: rtl/eth_serdes_hdr_err_inject.sv
// ---------------------------------------------------------------------------
// eth_serdes_hdr_err_inject
//
// Sync-header error injector on the SERDES loopback path (PHY TX -> PHY RX).
// Data words pass through with one cycle of latency. When armed, the 66b sync
// header is replaced by a programmable bad value in one of three patterns:
// a single block, one block every P blocks, or a burst of N consecutive blocks.
//
// Ports
//   clk, rst_n        SERDES parallel clock, asynchronous active-low reset
//   in_data/in_hdr    block from PHY TX
//   out_data/out_hdr  block to PHY RX (header possibly corrupted), 1-cycle latency
//   out_hdr_err       high when out_hdr of this cycle was forced
//   cfg_enable        master enable; low forces pass-through and returns to IDLE
//   cfg_mode          0 PASS, 1 SINGLE, 2 PERIODIC, 3 BURST
//   cfg_bad_hdr       header substituted on injection
//   cfg_period        PERIODIC spacing in blocks (0/1 = every block)
//   cfg_burst_len     BURST length in blocks (0 = 1)
//   start             one-cycle pulse arming the selected mode (latches cfg_*)
//   clear_count       synchronous clear of inject_count
//   busy              high whenever the FSM is not IDLE
//   inject_count      saturating count of corrupted blocks
// ---------------------------------------------------------------------------
module eth_serdes_hdr_err_inject #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    output logic                  out_hdr_err,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_mode,
    input  logic [HDR_WIDTH-1:0]  cfg_bad_hdr,
    input  logic [CNT_WIDTH-1:0]  cfg_period,
    input  logic [CNT_WIDTH-1:0]  cfg_burst_len,
    input  logic                  start,
    input  logic                  clear_count,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  inject_count
);

    typedef enum logic [1:0] {IDLE, HIT, GAP} state_t;

    localparam logic [1:0] MODE_PASS     = 2'd0;
    localparam logic [1:0] MODE_SINGLE   = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;
    localparam logic [1:0] MODE_BURST    = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                 state, state_n;
    logic [1:0]             mode_q;
    logic [HDR_WIDTH-1:0]   bad_hdr_q;
    logic [CNT_WIDTH-1:0]   period_q, burst_len_q;
    logic [CNT_WIDTH-1:0]   burst_cnt, burst_cnt_n;
    logic [CNT_WIDTH-1:0]   gap_cnt, gap_cnt_n;
    logic [CNT_WIDTH-1:0]   inject_count_n;
    logic [CNT_WIDTH-1:0]   burst_target;
    logic                   load_cfg;
    logic                   hit;

    // A block is corrupted only while armed in HIT and still enabled, so
    // dropping cfg_enable suppresses the injection on that very cycle.
    assign hit          = (state == HIT) && cfg_enable;
    assign burst_target = (burst_len_q == '0) ? CNT_ONE : burst_len_q;
    assign busy         = (state != IDLE);

    always_comb begin
        state_n     = state;
        burst_cnt_n = burst_cnt;
        gap_cnt_n   = gap_cnt;
        load_cfg    = 1'b0;

        if (!cfg_enable) begin
            state_n     = IDLE;
            burst_cnt_n = '0;
            gap_cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A start while busy never reaches here, so it is ignored.
                    if (start && (cfg_mode != MODE_PASS)) begin
                        state_n     = HIT;
                        load_cfg    = 1'b1;
                        burst_cnt_n = '0;
                        gap_cnt_n   = '0;
                    end
                end
                HIT: begin
                    case (mode_q)
                        MODE_SINGLE: state_n = IDLE;
                        MODE_BURST: begin
                            if ((burst_cnt + CNT_ONE) >= burst_target) begin
                                state_n     = IDLE;
                                burst_cnt_n = '0;
                            end else begin
                                burst_cnt_n = burst_cnt + CNT_ONE;
                            end
                        end
                        MODE_PERIODIC: begin
                            // Period 0/1 stays in HIT: every block is corrupted.
                            if (period_q > CNT_ONE) begin
                                state_n   = GAP;
                                gap_cnt_n = period_q - CNT_ONE;
                            end
                        end
                        default: state_n = IDLE;
                    endcase
                end
                GAP: begin
                    if (gap_cnt <= CNT_ONE) begin
                        state_n   = HIT;
                        gap_cnt_n = '0;
                    end else begin
                        gap_cnt_n = gap_cnt - CNT_ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A hit coinciding with clear_count leaves the count at 1 so that the
    // corruption on that cycle is not lost.
    always_comb begin
        inject_count_n = inject_count;
        if (clear_count) begin
            inject_count_n = hit ? CNT_ONE : '0;
        end else if (hit && (inject_count != CNT_MAX)) begin
            inject_count_n = inject_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            gap_cnt      <= '0;
            inject_count <= '0;
            mode_q       <= MODE_PASS;
            bad_hdr_q    <= '0;
            period_q     <= '0;
            burst_len_q  <= '0;
        end else begin
            state        <= state_n;
            burst_cnt    <= burst_cnt_n;
            gap_cnt      <= gap_cnt_n;
            inject_count <= inject_count_n;
            if (load_cfg) begin
                mode_q      <= cfg_mode;
                bad_hdr_q   <= cfg_bad_hdr;
                period_q    <= cfg_period;
                burst_len_q <= cfg_burst_len;
            end
        end
    end

    // Output register: the single cycle of latency for data and header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_hdr     <= '0;
            out_hdr_err <= 1'b0;
        end else begin
            out_data    <= in_data;
            out_hdr     <= hit ? bad_hdr_q : in_hdr;
            out_hdr_err <= hit;
        end
    end

endmodule

// File: tb/tb_eth_serdes_hdr_err_inject.sv
module tb_eth_serdes_hdr_err_inject;

    localparam int DW = 64;
    localparam int HW = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [HW-1:0] in_hdr;
    logic [DW-1:0] out_data;
    logic [HW-1:0] out_hdr;
    logic          out_hdr_err;
    logic          cfg_enable;
    logic [1:0]    cfg_mode;
    logic [HW-1:0] cfg_bad_hdr;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_burst_len;
    logic          start;
    logic          clear_count;
    logic          busy;
    logic [CW-1:0] inject_count;

    int errors = 0;
    int checks = 0;

    eth_serdes_hdr_err_inject #(
        .DATA_WIDTH(DW),
        .HDR_WIDTH (HW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_hdr       (in_hdr),
        .out_data     (out_data),
        .out_hdr      (out_hdr),
        .out_hdr_err  (out_hdr_err),
        .cfg_enable   (cfg_enable),
        .cfg_mode     (cfg_mode),
        .cfg_bad_hdr  (cfg_bad_hdr),
        .cfg_period   (cfg_period),
        .cfg_burst_len(cfg_burst_len),
        .start        (start),
        .clear_count  (clear_count),
        .busy         (busy),
        .inject_count (inject_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_hdr !== '0) begin errors++; $display("FAIL reset_hdr got=%b exp=00", out_hdr); end
        checks++; if (out_hdr_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", out_hdr_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (inject_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", inject_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass();
        logic [DW-1:0] d;
        logic [HW-1:0] h;
        cfg_enable = 1'b1;
        cfg_mode   = 2'd0;
        start      = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d = {$urandom, $urandom};
            h = HW'($urandom);
            in_data = d;
            in_hdr  = h;
            tick();
            start = 1'b0;
            checks++; if (out_data !== d) begin errors++; $display("FAIL pass_data[%0d] got=%h exp=%h", i, out_data, d); end
            checks++; if (out_hdr !== h) begin errors++; $display("FAIL pass_hdr[%0d] got=%b exp=%b", i, out_hdr, h); end
            checks++; if (out_hdr_err !== 1'b0) begin errors++; $display("FAIL pass_err[%0d] got=%b exp=0", i, out_hdr_err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy[%0d] got=%b exp=0", i, busy); end
        end
        checks++; if (inject_count !== '0) begin errors++; $display("FAIL pass_count got=%0d exp=0", inject_count); end
    endtask

    task automatic test_single();
        in_hdr      = 2'b01;
        cfg_mode    = 2'd1;
        cfg_bad_hdr = 2'b00;
        start       = 1'b1;
        in_data     = 64'hAAAA_0000_0000_0001;
        tick();
        start       = 1'b0;
        cfg_bad_hdr = 2'b11;  // must not affect the armed injection
        checks++; if (out_hdr_err !== 1'b0) begin errors++; $display("FAIL single_pre_err got=%b exp=0", out_hdr_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        in_data = 64'hAAAA_0000_0000_0002;
        tick();
        checks++; if (out_hdr !== 2'b00) begin errors++; $display("FAIL single_hdr got=%b exp=00", out_hdr); end
        checks++; if (out_hdr_err !== 1'b1) begin errors++; $display("FAIL single_err got=%b exp=1", out_hdr_err); end
        checks++; if (out_data !== 64'hAAAA_0000_0000_0002) begin errors++; $display("FAIL single_data got=%h exp=aaaa000000000002", out_data); end
        checks++; if (inject_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", inject_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
        in_data = 64'hAAAA_0000_0000_0003;
        tick();
        checks++; if (out_hdr !== 2'b01) begin errors++; $display("FAIL single_post_hdr got=%b exp=01", out_hdr); end
        checks++; if (out_hdr_err !== 1'b0) begin errors++; $display("FAIL single_post_err got=%b exp=0", out_hdr_err); end
    endtask

    task automatic test_periodic();
        logic          e;
        logic [DW-1:0] d;
        clear_cnt();
        checks++; if (inject_count !== '0) begin errors++; $display("FAIL per_clear got=%0d exp=0", inject_count); end
        in_hdr      = 2'b01;
        cfg_mode    = 2'd2;
        cfg_period  = 8'd4;
        cfg_bad_hdr = 2'b11;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            d       = {$urandom, $urandom};
            in_data = d;
            e       = ((i - 1) % 4 == 0);
            tick();
            checks++; if (out_hdr_err !== e) begin errors++; $display("FAIL per_err[%0d] got=%b exp=%b", i, out_hdr_err, e); end
            checks++; if (out_hdr !== (e ? 2'b11 : 2'b01)) begin errors++; $display("FAIL per_hdr[%0d] got=%b exp=%b", i, out_hdr, e ? 2'b11 : 2'b01); end
            checks++; if (out_data !== d) begin errors++; $display("FAIL per_data[%0d] got=%h exp=%h", i, out_data, d); end
        end
        checks++; if (inject_count !== 8'd10) begin errors++; $display("FAIL per_count got=%0d exp=10", inject_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL per_busy got=%b exp=1", busy); end
        cfg_enable = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL per_stop_busy got=%b exp=0", busy); end
        checks++; if (out_hdr_err !== 1'b0) begin errors++; $display("FAIL per_stop_err got=%b exp=0", out_hdr_err); end
        cfg_enable = 1'b1;
    endtask

    task automatic test_burst();
        clear_cnt();
        in_hdr        = 2'b01;
        cfg_mode      = 2'd3;
        cfg_burst_len = 8'd20;
        cfg_bad_hdr   = 2'b00;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        cfg_burst_len = 8'd3;  // latched value of 20 must hold
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++; if (out_hdr_err !== 1'b1 || out_hdr !== 2'b00) begin errors++; $display("FAIL burst_hit[%0d] got=%b/%b exp=1/00", i, out_hdr_err, out_hdr); end
            checks++; if (busy !== (i < 20)) begin errors++; $display("FAIL burst_busy[%0d] got=%b exp=%b", i, busy, (i < 20)); end
        end
        tick();
        checks++; if (out_hdr_err !== 1'b0 || out_hdr !== 2'b01) begin errors++; $display("FAIL burst_after got=%b/%b exp=0/01", out_hdr_err, out_hdr); end
        checks++; if (inject_count !== 8'd20) begin errors++; $display("FAIL burst_count got=%0d exp=20", inject_count); end
    endtask

    task automatic test_edge_cases();
        // burst_len 0 behaves as 1
        in_hdr        = 2'b10;
        cfg_mode      = 2'd3;
        cfg_burst_len = 8'd0;
        cfg_bad_hdr   = 2'b11;
        start         = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (out_hdr_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_hit got=err%b busy%b exp=err1 busy0", out_hdr_err, busy); end
        tick();
        checks++; if (out_hdr_err !== 1'b0 || out_hdr !== 2'b10) begin errors++; $display("FAIL len0_after got=%b/%b exp=0/10", out_hdr_err, out_hdr); end

        // period 1: every block, start while busy ignored
        cfg_mode   = 2'd2;
        cfg_period = 8'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                cfg_mode = 2'd1;
                start    = 1'b1;
            end
            tick();
            start = 1'b0;
            checks++; if (out_hdr_err !== 1'b1) begin errors++; $display("FAIL p1_hit[%0d] got=%b exp=1", i, out_hdr_err); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p1_busy got=%b exp=1", busy); end
        cfg_enable = 1'b0;
        tick();
        cfg_enable = 1'b1;

        // enable dropped mid-burst
        cfg_mode      = 2'd3;
        cfg_burst_len = 8'd10;
        start         = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (out_hdr_err !== 1'b1) begin errors++; $display("FAIL ena_hit[%0d] got=%b exp=1", i, out_hdr_err); end
        end
        cfg_enable = 1'b0;
        tick();
        checks++; if (out_hdr_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ena_drop got=err%b busy%b exp=err0 busy0", out_hdr_err, busy); end
        cfg_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_hdr_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ena_after[%0d] got=err%b busy%b exp=err0 busy0", i, out_hdr_err, busy); end
        end
    endtask

    task automatic test_counter_and_reset();
        clear_cnt();
        in_hdr      = 2'b01;
        cfg_mode    = 2'd2;
        cfg_period  = 8'd1;
        cfg_bad_hdr = 2'b00;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 260; i++) tick();
        checks++; if (inject_count !== 8'hFF) begin errors++; $display("FAIL sat_count got=%0d exp=255", inject_count); end
        checks++; if (out_hdr_err !== 1'b1) begin errors++; $display("FAIL sat_err got=%b exp=1", out_hdr_err); end
        clear_count = 1'b1;
        tick();
        checks++; if (inject_count !== 8'd1) begin errors++; $display("FAIL clr_hit_count got=%0d exp=1", inject_count); end
        cfg_enable = 1'b0;
        tick();
        clear_count = 1'b0;
        checks++; if (inject_count !== 8'd0) begin errors++; $display("FAIL clr_only_count got=%0d exp=0", inject_count); end
        cfg_enable = 1'b1;

        // reset in the middle of a periodic run
        cfg_period = 8'd3;
        start      = 1'b1;
        tick();
        start   = 1'b0;
        in_data = 64'h1234_5678_9ABC_DEF0;
        tick();
        tick();
        checks++; if (inject_count !== 8'd1) begin errors++; $display("FAIL rst_pre_count got=%0d exp=1", inject_count); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_data !== '0 || out_hdr !== '0 || out_hdr_err !== 1'b0) begin errors++; $display("FAIL rst_mid_out got=%h/%b/%b exp=0/00/0", out_data, out_hdr, out_hdr_err); end
        checks++; if (busy !== 1'b0 || inject_count !== '0) begin errors++; $display("FAIL rst_mid_state got=busy%b cnt%0d exp=busy0 cnt0", busy, inject_count); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 64'hC0DE_0000_0000_0000 + 64'(i);
            tick();
            checks++; if (out_hdr_err !== 1'b0 || out_hdr !== 2'b01 || busy !== 1'b0) begin errors++; $display("FAIL rst_after[%0d] got=err%b hdr%b busy%b exp=err0 hdr01 busy0", i, out_hdr_err, out_hdr, busy); end
            checks++; if (out_data !== 64'hC0DE_0000_0000_0000 + 64'(i)) begin errors++; $display("FAIL rst_after_data[%0d] got=%h", i, out_data); end
        end
    endtask

    initial begin
        in_data       = '0;
        in_hdr        = '0;
        cfg_enable    = 1'b0;
        cfg_mode      = 2'd0;
        cfg_bad_hdr   = '0;
        cfg_period    = '0;
        cfg_burst_len = '0;
        start         = 1'b0;
        clear_count   = 1'b0;
        test_reset();
        test_pass();
        test_single();
        test_periodic();
        test_burst();
        test_edge_cases();
        test_counter_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
